// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault-injection campaign sequencer: one golden pass, then one pass per
// fault index, each compacted into a MISR signature and compared with the golden one.
module fault_campaign_ctrl #(
   parameter int              IDXW   = 32,
   parameter int              CYCW   = 16,
   parameter int              SIGW   = 32,
   parameter logic [SIGW-1:0] POLY   = 32'h04C11DB7,
   parameter int              RSTCYC = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [IDXW-1:0] num_faults,
   input  logic [CYCW-1:0] test_cycles,
   input  logic [SIGW-1:0] observe,
   output logic [IDXW-1:0] stuck,
   output logic            dut_rst_n,
   output logic            test_active,
   output logic            busy,
   output logic            done,
   output logic            result_valid,
   output logic [IDXW-1:0] result_idx,
   output logic            result_detected,
   output logic [IDXW-1:0] detected_count,
   output logic [IDXW-1:0] undetected_count
);

   localparam int RCW  = $clog2(RSTCYC + 1);
   localparam int CNTW = (CYCW > RCW) ? CYCW : RCW;

   typedef enum logic [2:0] {
      s_idle, s_grst, s_grun, s_gcap, s_frst, s_frun, s_fcmp, s_done
   } state_t;

   state_t            state, state_nxt;
   logic [CNTW-1:0]   cnt;
   logic [CYCW-1:0]   tlen;
   logic [IDXW-1:0]   nf;
   logic [IDXW-1:0]   k;
   logic [SIGW-1:0]   sig;
   logic [SIGW-1:0]   golden;
   logic [SIGW-1:0]   misr_nxt;
   logic [IDXW-1:0]   det_cnt;
   logic [IDXW-1:0]   undet_cnt;
   logic              active_q;
   logic              rst_last;
   logic              run_last;
   logic              last_fault;
   logic              mismatch;

   assign misr_nxt   = {sig[SIGW-2:0], 1'b0} ^ (sig[SIGW-1] ? POLY : '0) ^ observe;
   assign rst_last   = (cnt == CNTW'(RSTCYC - 1));
   assign run_last   = (cnt == (CNTW'(tlen) - CNTW'(1)));
   assign last_fault = (k == (nf - IDXW'(1)));
   assign mismatch   = (sig != golden);

   assign test_active      = active_q;
   assign result_idx       = k;
   assign detected_count   = det_cnt;
   assign undetected_count = undet_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= s_idle;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt       = state;
      stuck           = '1;
      dut_rst_n       = 1'b1;
      busy            = 1'b1;
      done            = 1'b0;
      result_valid    = 1'b0;
      result_detected = 1'b0;
      case (state)
         s_idle: begin
            busy = 1'b0;
            if (start) state_nxt = s_grst;
         end
         s_grst: begin
            dut_rst_n = 1'b0;
            if (rst_last) state_nxt = s_grun;
         end
         s_grun: if (run_last) state_nxt = s_gcap;
         s_gcap: state_nxt = (nf == '0) ? s_done : s_frst;
         s_frst: begin
            stuck     = k;
            dut_rst_n = 1'b0;
            if (rst_last) state_nxt = s_frun;
         end
         s_frun: begin
            stuck = k;
            if (run_last) state_nxt = s_fcmp;
         end
         s_fcmp: begin
            stuck           = k;
            result_valid    = 1'b1;
            result_detected = mismatch;
            state_nxt       = last_fault ? s_done : s_frst;
         end
         s_done: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) state_nxt = s_grst;
         end
         default: state_nxt = s_idle;
      endcase
      // Abort only matters mid-campaign; in IDLE/DONE a simultaneous start wins.
      if (busy && abort) state_nxt = s_idle;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt       <= '0;
         tlen      <= '0;
         nf        <= '0;
         k         <= '0;
         sig       <= '0;
         golden    <= '0;
         det_cnt   <= '0;
         undet_cnt <= '0;
         active_q  <= 1'b0;
      end else begin
         active_q <= (state_nxt == s_grun) || (state_nxt == s_frun);
         // Phase counter restarts on every state change.
         cnt <= (state_nxt != state) ? '0 : cnt + CNTW'(1);
         case (state)
            s_idle, s_done: begin
               if (start) begin
                  nf        <= num_faults;
                  tlen      <= (test_cycles == '0) ? CYCW'(1) : test_cycles;
                  det_cnt   <= '0;
                  undet_cnt <= '0;
                  k         <= '0;
               end
            end
            s_grst, s_frst: sig <= '0;
            s_grun, s_frun: sig <= misr_nxt;
            s_gcap:         golden <= sig;
            s_fcmp: begin
               if (mismatch) det_cnt   <= det_cnt + IDXW'(1);
               else          undet_cnt <= undet_cnt + IDXW'(1);
               if (!last_fault && !abort) k <= k + IDXW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Bench for fault_campaign_ctrl: a toy counter DUT with per-index injected errors, a
// cycle-timing reference derived from the pass-length arithmetic, and MISR signatures.
module tb_fault_campaign_ctrl;

   localparam int          IDXW   = 32;
   localparam int          CYCW   = 16;
   localparam int          SIGW   = 32;
   localparam int          RSTCYC = 2;
   localparam logic [31:0] POLY   = 32'h04C11DB7;

   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [31:0] num_faults;
   logic [15:0] test_cycles;
   logic [31:0] observe;
   logic [31:0] stuck, result_idx, detected_count, undetected_count;
   logic        dut_rst_n, test_active, busy, done, result_valid, result_detected;

   fault_campaign_ctrl #(
      .IDXW(IDXW), .CYCW(CYCW), .SIGW(SIGW), .POLY(POLY), .RSTCYC(RSTCYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_faults(num_faults), .test_cycles(test_cycles), .observe(observe),
      .stuck(stuck), .dut_rst_n(dut_rst_n), .test_active(test_active), .busy(busy),
      .done(done), .result_valid(result_valid), .result_idx(result_idx),
      .result_detected(result_detected), .detected_count(detected_count),
      .undetected_count(undetected_count)
   );

   always #5 clk = ~clk;

   typedef logic [133:0] vec_t;
   typedef struct {
      int         nf;
      int         tc;
      int         a;
      logic [7:0] mask;
      int         exp_done;
      int         exp_det;
      int         exp_undet;
   } vec_s;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] seed;
   logic [31:0] err_tab [64];
   logic [31:0] dut_cnt = 32'h0;

   function automatic logic [31:0] pat(input logic [31:0] i);
      return (i * 32'h9E3779B9) ^ seed;
   endfunction

   function automatic logic [31:0] ferr(input logic [31:0] s);
      return (s < 32'd64) ? err_tab[s[5:0]] : 32'h0;
   endfunction

   // Toy DUT: a counter cleared by dut_rst_n; a faulty index corrupts its first window value.
   always @(posedge clk) begin
      if (!dut_rst_n) dut_cnt <= 32'h0;
      else            dut_cnt <= dut_cnt + 32'h1;
   end
   always_comb observe = pat(dut_cnt) ^ ((dut_cnt == 32'h0) ? ferr(stuck) : 32'h0);

   function automatic logic [31:0] misr_of(input logic [31:0] err, input int t);
      logic [31:0] s;
      s = 32'h0;
      for (int i = 0; i < t; i++)
         s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ pat(32'(i)) ^ ((i == 0) ? err : 32'h0);
      return s;
   endfunction

   function automatic vec_t pack(input logic b, d, r, t, v, det,
                                 input logic [31:0] s, i, dc, uc);
      return {b, d, r, t, v, det, s, i, dc, uc};
   endfunction

   function automatic vec_t sample();
      return pack(busy, done, dut_rst_n, test_active, result_valid, result_detected, stuck,
                  result_valid ? result_idx : 32'h0, detected_count, undetected_count);
   endfunction

   task automatic check(input string name, input vec_t got, input vec_t exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic set_errs(input logic [63:0] mask);
      for (int i = 0; i < 64; i++)
         err_tab[i] = mask[i] ? (32'(i + 1) * 32'h01010101) : 32'h0;
   endtask

   // Runs one campaign and checks every cycle against the pass-timing arithmetic.
   task automatic run_campaign(input int id, input int nf, input int tc, input int a,
                               input bit chatter, output int done_c,
                               output int dc_out, output int uc_out);
      int          t, l, end_c, last_busy, stop, p, o, j, c_eff, dcnt, ucnt;
      bit          is_rst, is_run, rv;
      bit          det_ref[];
      logic [31:0] gsig;
      vec_t        e;
      t         = (tc == 0) ? 1 : tc;
      l         = RSTCYC + t + 1;
      end_c     = (nf + 1) * l;
      last_busy = (a > 0) ? a : end_c;
      stop      = (a > 0) ? a + 3 : end_c + 2;
      det_ref   = new[(nf > 0) ? nf : 1];
      gsig      = misr_of(32'h0, t);
      for (int q = 0; q < nf; q++) det_ref[q] = (misr_of(ferr(32'(q)), t) != gsig);
      done_c = -1;
      @(negedge clk);
      start       = 1'b1;
      abort       = 1'b0;
      num_faults  = 32'(nf);
      test_cycles = 16'(tc);
      for (int c = 1; c <= stop; c++) begin
         @(negedge clk);
         c_eff = (a > 0 && c > a) ? a + 1 : c;
         dcnt  = 0;
         ucnt  = 0;
         for (int q = 0; q < nf; q++)
            if ((q + 2) * l < c_eff) begin
               if (det_ref[q]) dcnt++;
               else            ucnt++;
            end
         if (a > 0 && c > a)
            e = pack(0, 0, 1, 0, 0, 0, '1, 0, 32'(dcnt), 32'(ucnt));
         else if (c > end_c)
            e = pack(0, 1, 1, 0, 0, 0, '1, 0, 32'(dcnt), 32'(ucnt));
         else begin
            p      = (c - 1) / l;
            o      = (c - 1) % l;
            j      = p - 1;
            is_rst = (o < RSTCYC);
            is_run = !is_rst && (o < RSTCYC + t);
            rv     = (o == l - 1) && (p >= 1);
            e = pack(1, 0, !is_rst, is_run, rv, rv ? det_ref[j] : 1'b0,
                     (p >= 1) ? 32'(j) : '1, rv ? 32'(j) : 32'h0, 32'(dcnt), 32'(ucnt));
         end
         check($sformatf("run%0d_c%0d", id, c), sample(), e);
         if (done === 1'b1 && done_c < 0) done_c = c;
         start = chatter && (c <= last_busy) && ($urandom_range(0, 3) == 0);
         abort = (c == a);
         if (chatter) begin
            num_faults  = $urandom;
            test_cycles = 16'($urandom);
         end
      end
      start  = 1'b0;
      abort  = 1'b0;
      dc_out = int'(detected_count);
      uc_out = int'(undetected_count);
   endtask

   vec_s tbl [5];
   int   done_c, dc, uc, nf, tc, l, a;

   initial begin
      tbl[0] = '{4, 5, 0,  8'b00001010, 41, 2, 2};   // basic campaign
      tbl[1] = '{4, 5, 0,  8'b00001010, 41, 2, 2};   // restart from DONE, same results
      tbl[2] = '{5, 5, 28, 8'b00001010, -1, 1, 1};   // abort during FRUN of fault 2
      tbl[3] = '{0, 5, 0,  8'b00000000,  9, 0, 0};   // zero faults
      tbl[4] = '{3, 0, 0,  8'b00000101, 17, 2, 1};   // test_cycles = 0

      rst_n       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      num_faults  = 32'h0;
      test_cycles = 16'h0;
      seed        = 32'h1234_5678;
      set_errs(64'h0);
      repeat (3) @(negedge clk);
      check("reset", sample(), pack(0, 0, 1, 0, 0, 0, '1, 0, 0, 0));
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         set_errs({56'h0, tbl[i].mask});
         run_campaign(i, tbl[i].nf, tbl[i].tc, tbl[i].a, 1'b1, done_c, dc, uc);
         check($sformatf("tbl%0d_done_cycle", i), vec_t'(done_c), vec_t'(tbl[i].exp_done));
         check($sformatf("tbl%0d_detected", i), vec_t'(dc), vec_t'(tbl[i].exp_det));
         check($sformatf("tbl%0d_undetected", i), vec_t'(uc), vec_t'(tbl[i].exp_undet));
      end

      // Abort in DONE is ignored.
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("abort_in_done", sample(), pack(0, 1, 1, 0, 0, 0, '1, 0, 2, 1));

      // Start and abort together in DONE: start wins, counters clear.
      start = 1'b1; abort = 1'b1; num_faults = 32'd1; test_cycles = 16'd1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      check("start_beats_abort", sample(), pack(1, 0, 0, 0, 0, 0, '1, 0, 0, 0));
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("abort_in_grst", sample(), pack(0, 0, 1, 0, 0, 0, '1, 0, 0, 0));

      // Reset in the middle of a campaign.
      set_errs(64'h0A);
      start = 1'b1; num_faults = 32'd4; test_cycles = 16'd5;
      @(negedge clk); start = 1'b0;
      repeat (19) @(negedge clk);
      check("pre_reset_counts", vec_t'({detected_count, undetected_count}), vec_t'({32'd0, 32'd1}));
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_reset", sample(), pack(0, 0, 1, 0, 0, 0, '1, 0, 0, 0));
      rst_n = 1'b1;

      for (int r = 0; r < 20; r++) begin
         seed = $urandom;
         set_errs({$urandom, $urandom});
         nf = $urandom_range(0, 6);
         tc = $urandom_range(0, 12);
         l  = RSTCYC + ((tc == 0) ? 1 : tc) + 1;
         a  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (nf + 1) * l) : 0;
         run_campaign(100 + r, nf, tc, a, 1'b1, done_c, dc, uc);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fault_campaign_ctrl.md
# fault_campaign_ctrl

Sequencer for stuck-at fault-injection campaigns. It sits directly upstream of every stuck-at injection cell in the testbench and owns the global fault-index bus those cells compare against. It runs one golden (fault-free) pass, then one pass per fault index. Each pass compacts the DUT outputs into a MISR signature, compares it with the golden signature, and reports per-fault detection plus running totals.

## Interface
- IDXW, 32: width of the fault-index bus and of the counters.
- CYCW, 16: width of the test-window length.
- SIGW, 32: width of the observed bus and of the signature.
- POLY, 32'h04C11DB7: MISR feedback polynomial, SIGW bits.
- RSTCYC, 2: number of cycles DUT reset is held at the start of every pass; must be at least 1.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begins a campaign; sampled only in IDLE or DONE.
- abort  in  1  ends the campaign; honoured in any busy state.
- num_faults  in  IDXW  number of fault sites; sampled with start.
- test_cycles  in  CYCW  length of the test window; sampled with start; 0 is treated as 1.
- observe  in  SIGW  DUT outputs to compact.
- stuck  out  IDXW  fault index driven to the injection cells; all-ones means no fault.
- dut_rst_n  out  1  active-low reset to the DUT.
- test_active  out  1  high while the current pass's test window is open.
- busy  out  1  campaign in progress.
- done  out  1  level; high in DONE.
- result_valid  out  1  one-cycle pulse per completed fault pass.
- result_idx  out  IDXW  fault index of the current result.
- result_detected  out  1  1 if the pass signature differs from the golden signature.
- detected_count  out  IDXW  number of detected faults.
- undetected_count  out  IDXW  number of undetected faults.

## Operation
- States and what each drives:
  - IDLE: stuck all-ones, dut_rst_n=1.
  - GRST: golden pass, DUT held in reset.
  - GRUN: golden pass, test window open.
  - GCAP: golden signature captured.
  - FRST: fault pass, DUT held in reset.
  - FRUN: fault pass, test window open.
  - FCMP: fault pass, signature compared.
  - DONE: campaign finished.
- IDLE/DONE, start=1:
  - Latch num_faults and T = max(test_cycles, 1).
  - Clear both counters, set k=0, go to GRST.
- GRST, then FRST:
  - dut_rst_n=0 for RSTCYC cycles.
  - Signature cleared to 0.
  - stuck = all-ones in GRST, k in FRST.
- GRUN, then FRUN:
  - T cycles with test_active=1.
  - Each cycle: sig <= {sig[SIGW-2:0],1'b0} ^ (sig[SIGW-1] ? POLY : 0) ^ observe.
- GCAP, one cycle:
  - golden <= sig.
  - If num_faults==0, go to DONE; otherwise go to FRST.
- FCMP, one cycle:
  - result_valid=1, result_idx=k, result_detected=(sig!=golden).
  - Increment the matching counter.
  - If k==num_faults-1, go to DONE; otherwise k<=k+1 and go to FRST.
- stuck holds k across FRST, FRUN and FCMP. It is all-ones in IDLE, GRST, GRUN, GCAP and DONE.
- busy=1 in every state except IDLE and DONE.
- DONE: done=1, counters hold. start launches a new campaign.
- start while busy: ignored.
- abort while busy:
  - Next cycle: IDLE, stuck all-ones, dut_rst_n=1.
  - Counters keep their partial values.
  - No result_valid is issued for the interrupted pass.
- abort and start in the same cycle in IDLE/DONE: start wins; abort has no effect outside busy states.

## Timing
- Reset values: state IDLE, stuck all-ones, dut_rst_n=1, and all other outputs, counters, k, sig and golden = 0.
- Pass length L = RSTCYC + T + 1 cycles.
- With start sampled in cycle 0:
  - golden pass occupies cycles 1..L;
  - fault pass j occupies cycles (j+1)L+1 .. (j+2)L;
  - result_valid for fault j is asserted in cycle (j+2)L;
  - done rises in cycle (N+1)L+1.
- test_active is registered. The observe value compacted in a cycle is the value present in that same cycle.
- Counters update on the clock edge that ends the FCMP cycle, so the new value is visible one cycle after result_valid.
- Reset asserted mid-campaign returns everything to reset values on the next edge.

## Test plan
- Reset check: drive rst_n=0 for 3 cycles -> stuck=32'hFFFFFFFF, dut_rst_n=1, busy=0, done=0, both counters 0.
- Basic campaign:
  - Setup: num_faults=4, test_cycles=5, RSTCYC=2; the DUT model makes observe differ only when stuck is 1 or 3.
  - Required: result_valid pulses at cycles 16, 24, 32, 40 with detected = 0, 1, 0, 1.
  - Required: detected_count=2, undetected_count=2, done at cycle 41.
- Zero faults: num_faults=0 -> exactly one golden pass, no result_valid pulse, done at cycle L+1=9 when test_cycles=5.
- test_cycles=0: test_active is high for exactly 1 cycle per pass; L=4.
- Abort:
  - Stimulus: assert abort during FRUN of fault 2.
  - Required: next cycle IDLE, stuck all-ones, counters equal the results of faults 0 and 1, no result for fault 2.
  - start pulses while busy do not alter the timing.
- Restart from DONE: start again -> counters cleared, golden recomputed, identical results to the first run.
